// File: rtl/uart_word_tx.sv
// UART word transmitter: sends an NBITS_D-bit word as NBITS_D/DBIT back-to-back frames,
// byte 0 first, each byte LSB first. Define UART_WORD_TX_PARITY_EN for an even parity bit per frame.
`timescale 1ns/1ps
module uart_word_tx #(
  parameter int NBITS_D = 16,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_tx_start,
  input  logic [NBITS_D-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int NBYTES = NBITS_D / DBIT;
  localparam int BW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t             r_state, w_state;
  logic [3:0]         r_tick, w_tick;
  logic [BW-1:0]      r_bit, w_bit;
  logic [IW-1:0]      r_idx, w_idx;
  logic [NBITS_D-1:0] r_shift, w_shift;
  logic               r_tx, w_tx;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
`ifdef UART_WORD_TX_PARITY_EN
  logic               r_par, w_par;
`endif

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_tick  <= 4'd0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_bit   <= w_bit;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
`ifdef UART_WORD_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_tx    = 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
    w_par   = r_par;
`endif
    case (r_state)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (i_tx_start && !r_done) begin
          w_state = START;
          w_shift = i_data;
          w_tick  = 4'd0;
          w_bit   = '0;
          w_idx   = '0;
          w_busy  = 1'b1;
        end else begin
          w_state = IDLE;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (r_tick == 4'd15) begin
            w_state = DATA;
            w_tick  = 4'd0;
`ifdef UART_WORD_TX_PARITY_EN
            w_par   = 1'b0;
`endif
          end else begin
            w_tick = r_tick + 4'd1;
          end
        end else begin
          w_tick = r_tick;
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (r_tick == 4'd15) begin
            w_tick  = 4'd0;
            w_shift = {1'b0, r_shift[NBITS_D-1:1]};
`ifdef UART_WORD_TX_PARITY_EN
            w_par   = r_par ^ r_shift[0];
`endif
            if (r_bit == BW'(DBIT - 1)) begin
              w_bit = '0;
`ifdef UART_WORD_TX_PARITY_EN
              w_state = PARITY;
`else
              w_state = STOP;
`endif
            end else begin
              w_bit = r_bit + BW'(1);
            end
          end else begin
            w_tick = r_tick + 4'd1;
          end
        end else begin
          w_tick = r_tick;
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (r_tick == 4'd15) begin
            w_state = STOP;
            w_tick  = 4'd0;
          end else begin
            w_tick = r_tick + 4'd1;
          end
        end else begin
          w_tick = r_tick;
        end
      end
`endif
      STOP: begin
        if (i_s_tick) begin
          if (r_tick == 4'(SB_TICK - 1)) begin
            w_tick = 4'd0;
            if (r_idx == IW'(NBYTES - 1)) begin
              w_state = IDLE;
              w_idx   = '0;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_state = START;
              w_idx   = r_idx + IW'(1);
            end
          end else begin
            w_tick = r_tick + 4'd1;
          end
        end else begin
          w_tick = r_tick;
        end
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase

    // Line level follows the state being entered so o_tx changes with the state flop.
    case (w_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_shift[0];
`ifdef UART_WORD_TX_PARITY_EN
      PARITY:  w_tx = w_par;
`endif
      default: w_tx = 1'b1;
    endcase
  end

  assign o_tx      = r_tx;
  assign o_busy    = r_busy;
  assign o_tx_done = r_done;

endmodule
